// File: rtl/echo_det_pkg.sv
// rtl/echo_det_pkg.sv - shared state encoding and default widths for the echo detector
package echo_det_pkg;

  localparam int ECHO_N  = 16;
  localparam int ECHO_CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_LISTEN = 2'd2,
    ST_DONE   = 2'd3
  } echo_state_t;

endpackage

// File: rtl/echo_envelope.sv
// rtl/echo_envelope.sv - magnitude and first-order shift-smoothed envelope follower
module echo_envelope
  import echo_det_pkg::*;
#(
  parameter int N = ECHO_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [N-1:0] X,
  input  logic [2:0]          k,
  output logic [N-1:0]        env,
  output logic [N-1:0]        env_next
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};

  logic [N-1:0]        a;
  logic signed [N:0]   diff;
  logic signed [N:0]   step;

  // the most negative input has no positive twin, so clamp it
  always_comb begin
    a = X;
    if (X == MOST_NEG)
      a = MOST_POS;
    else if (X[N-1])
      a = ~X + {{(N-1){1'b0}}, 1'b1};
  end

  // env and a both stay below 2^(N-1), so the N-bit truncated sum is exact
  always_comb begin
    diff     = $signed({1'b0, a}) - $signed({1'b0, env});
    step     = diff >>> k;
    env_next = N'({1'b0, env} + step);
  end

  always_ff @(posedge clk) begin
    if (rst)
      env <= '0;
    else if (en)
      env <= env_next;
  end

endmodule

// File: rtl/echo_detector.sv
// rtl/echo_detector.sv - blanking / listen FSM that times the first envelope crossing
module echo_detector
  import echo_det_pkg::*;
#(
  parameter int N  = ECHO_N,
  parameter int CW = ECHO_CW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [N-1:0] X,
  input  logic                start,
  input  logic [2:0]          k,
  input  logic [N-1:0]        thr,
  input  logic [CW-1:0]       blank,
  input  logic [CW-1:0]       timeout,
  output logic [N-1:0]        env,
  output logic [CW-1:0]       tof,
  output logic                det,
  output logic                tmo,
  output logic                busy
);

  echo_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc, tof_n;
  logic [CW:0]   cnt_p1;
  logic          det_n, tmo_n;
  logic [N-1:0]  env_next;

  echo_envelope #(.N(N)) u_env (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .X        (X),
    .k        (k),
    .env      (env),
    .env_next (env_next)
  );

  // carry out of cnt+1 means the counter is already full: hold it there
  assign cnt_p1  = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign cnt_inc = cnt_p1[CW] ? cnt : cnt_p1[CW-1:0];
  assign busy    = (state == ST_BLANK) || (state == ST_LISTEN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tof_n   = tof;
    det_n   = det;
    tmo_n   = tmo;
    if (start) begin
      cnt_n   = '0;
      det_n   = 1'b0;
      tmo_n   = 1'b0;
      state_n = (blank == '0) ? ST_LISTEN : ST_BLANK;
    end else if (en) begin
      case (state)
        ST_BLANK: begin
          cnt_n = cnt_inc;
          if (cnt_p1 >= {1'b0, blank})
            state_n = ST_LISTEN;
        end
        ST_LISTEN: begin
          // detection is tested first so it wins a tie with the timeout
          if (env_next >= thr) begin
            tof_n   = cnt;
            det_n   = 1'b1;
            state_n = ST_DONE;
          end else if (cnt == timeout) begin
            tof_n   = cnt;
            tmo_n   = 1'b1;
            state_n = ST_DONE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      tof   <= '0;
      det   <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tof   <= tof_n;
      det   <= det_n;
      tmo   <= tmo_n;
    end
  end

endmodule

// File: tb/tb_echo_detector.sv
// tb/tb_echo_detector.sv - scoreboard bench for echo_detector
module tb_echo_detector;

  localparam int N  = 16;
  localparam int CW = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                start = 1'b0;
  logic signed [N-1:0] X = '0;
  logic [2:0]          k = '0;
  logic [N-1:0]        thr = '0;
  logic [CW-1:0]       blank = '0;
  logic [CW-1:0]       timeout = '0;
  logic [N-1:0]        env;
  logic [CW-1:0]       tof;
  logic                det;
  logic                tmo;
  logic                busy;

  echo_detector #(.N(N), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .X       (X),
    .start   (start),
    .k       (k),
    .thr     (thr),
    .blank   (blank),
    .timeout (timeout),
    .env     (env),
    .tof     (tof),
    .det     (det),
    .tmo     (tmo),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          det;
    logic          tmo;
    logic [CW-1:0] tof;
  } res_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] env_q[$];
  res_t         res_q[$];
  logic [N-1:0] env_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] env_step(input logic [N-1:0] e, input logic signed [N-1:0] x,
                                            input logic [2:0] kk);
    int xi, a, d;
    xi = x;
    a  = (xi < 0) ? -xi : xi;
    if (a > 32767) a = 32767;
    d = a - int'(e);
    d = d >>> kk;
    return N'(int'(e) + d);
  endfunction

  task automatic strobe(input logic signed [N-1:0] x, input int gap);
    en    = 1'b1;
    X     = x;
    env_m = env_step(env_m, x, k);
    env_q.push_back(env_m);
    @(negedge clk);
    en = 1'b0;
    chk("env", env, env_q.pop_front());
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic arm(input bit with_en, input logic signed [N-1:0] x);
    start = 1'b1;
    if (with_en) begin
      en    = 1'b1;
      X     = x;
      env_m = env_step(env_m, x, k);
      env_q.push_back(env_m);
    end
    @(negedge clk);
    start = 1'b0;
    en    = 1'b0;
    if (with_en) chk("env_arm", env, env_q.pop_front());
    chk("flags_clr", {det, tmo}, 0);
    chk("busy_arm", busy, 1);
  endtask

  task automatic run(input logic signed [N-1:0] x0, input logic signed [N-1:0] x1, input int sw,
                     input int gap, input int max, input res_t exp);
    bit   found;
    int   got;
    res_t r;
    found = 0;
    got   = -1;
    res_q.push_back(exp);
    for (int i = 0; i < max && !found; i++) begin
      strobe((i < sw) ? x0 : x1, gap);
      if (det || tmo) begin
        found = 1;
        got   = i;
      end
    end
    r = res_q.pop_front();
    if (!found) begin
      chk("flag_seen", 0, 1);
    end else begin
      chk("strobe_idx", got, r.idx);
      chk("det", det, r.det);
      chk("tmo", tmo, r.tmo);
      chk("tof", tof, r.tof);
      chk("excl", det & tmo, 0);
      chk("busy_done", busy, 0);
    end
  endtask

  initial begin
    logic [N-1:0] e;
    int           idx;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_env", env, 0);
    chk("rst_tof", tof, 0);
    chk("rst_det", det, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_busy", busy, 0);

    // blanked strobes, then detection on the first listened strobe
    k = 3'd0; thr = 16'd1000; blank = 16'd3; timeout = 16'd100;
    arm(0, 0);
    run(16'sd2000, 16'sd2000, 0, 4, 10, '{idx: 3, det: 1'b1, tmo: 1'b0, tof: 16'd3});

    // silence until timeout, then DONE holds the result
    blank = 16'd0; timeout = 16'd5;
    arm(0, 0);
    run(16'sd0, 16'sd0, 0, 1, 10, '{idx: 5, det: 1'b0, tmo: 1'b1, tof: 16'd5});
    strobe(16'sd5000, 1);
    chk("hold_det", det, 0);
    chk("hold_tmo", tmo, 1);
    chk("hold_tof", tof, 5);

    // smoothed step response
    strobe(16'sd0, 1);
    k = 3'd2;
    strobe(16'sh7FFF, 1);
    chk("step1", env, 16'h1FFF);
    strobe(16'sh7FFF, 1);
    chk("step2", env, 16'h37FF);
    k = 3'd0;
    strobe(16'sd0, 1);
    k = 3'd2; thr = 16'h7000; timeout = 16'd100;
    e = env_m;
    idx = -1;
    for (int j = 0; j < 40 && idx < 0; j++) begin
      e = env_step(e, 16'sh7FFF, k);
      if (e >= thr) idx = j;
    end
    arm(0, 0);
    run(16'sd0, 16'sh7FFF, 0, 1, 40, '{idx: idx, det: 1'b1, tmo: 1'b0, tof: CW'(idx)});

    // most negative input saturates
    k = 3'd0;
    strobe(-16'sd32768, 1);
    chk("env_sat", env, 16'h7FFF);

    // start coincident with en leaves cnt at 0; restart from LISTEN
    thr = 16'h7000; blank = 16'd0; timeout = 16'd3;
    arm(1, 0);
    run(16'sd0, 16'sd0, 0, 1, 8, '{idx: 3, det: 1'b0, tmo: 1'b1, tof: 16'd3});
    timeout = 16'd50;
    arm(0, 0);
    strobe(16'sd0, 1);
    strobe(16'sd0, 1);
    timeout = 16'd4;
    arm(0, 0);
    run(16'sd0, 16'sd0, 0, 1, 8, '{idx: 4, det: 1'b0, tmo: 1'b1, tof: 16'd4});

    // detection and timeout on the same strobe
    thr = 16'd1000; timeout = 16'd2;
    arm(0, 0);
    run(16'sd0, 16'sd2000, 2, 1, 6, '{idx: 2, det: 1'b1, tmo: 1'b0, tof: 16'd2});

    // reset mid-measurement overrides start and en
    thr = 16'h7000; timeout = 16'd100;
    arm(0, 0);
    strobe(16'sd0, 1);
    strobe(16'sd0, 1);
    chk("busy_listen", busy, 1);
    rst = 1'b1; start = 1'b1; en = 1'b1; X = 16'sh7FFF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; en = 1'b0;
    env_m = '0;
    chk("abort_env", env, 0);
    chk("abort_tof", tof, 0);
    chk("abort_det", det, 0);
    chk("abort_tmo", tmo, 0);
    chk("abort_busy", busy, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
